// File: rtl/spram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: fetch (p0) and load/store (p1).
// Latency: grant same cycle, response (read data or write ack) one cycle after grant.
// Backpressure: requesters hold until gnt; responses are never stalled.
module spram_arbiter #(
    parameter int AddrBusWidth = 32,
    parameter int DataBusWidth = 32,
    parameter bit RoundRobin   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [AddrBusWidth-1:0] p0_addr,
    input  logic [DataBusWidth-1:0] p0_wdata,
    output logic                    p0_gnt,
    output logic                    p0_rvalid,
    output logic [DataBusWidth-1:0] p0_rdata,
    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic [AddrBusWidth-1:0] p1_addr,
    input  logic [DataBusWidth-1:0] p1_wdata,
    output logic                    p1_gnt,
    output logic                    p1_rvalid,
    output logic [DataBusWidth-1:0] p1_rdata,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [AddrBusWidth-1:0] mem_addr,
    output logic [DataBusWidth-1:0] mem_wdata,
    input  logic [DataBusWidth-1:0] mem_rdata
);

    logic last_gnt_q, last_gnt_d;
    logic resp_vld_q, resp_vld_d;
    logic resp_port_q, resp_port_d;
    logic resp_we_q, resp_we_d;
    logic p0_wins;
    logic any_gnt;
    logic sel_we;
    logic [DataBusWidth-1:0] rdata_sel;

    always_comb begin
        // last_gnt_q=1 means port 1 won most recently, so port 0 takes the next contention
        p0_wins   = ~p1_req | (RoundRobin == 1'b0) | last_gnt_q;
        p0_gnt    = p0_req & p0_wins;
        p1_gnt    = p1_req & ~p0_gnt;
        any_gnt   = p0_gnt | p1_gnt;

        mem_addr  = '0;
        mem_wdata = '0;
        sel_we    = 1'b0;
        if (p0_gnt) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            sel_we    = p0_we;
        end else if (p1_gnt) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            sel_we    = p1_we;
        end
        mem_we = any_gnt & sel_we;
        mem_re = any_gnt & ~sel_we;

        last_gnt_d  = any_gnt ? p1_gnt : last_gnt_q;
        resp_vld_d  = any_gnt;
        resp_port_d = any_gnt ? p1_gnt : resp_port_q;
        resp_we_d   = any_gnt ? sel_we : resp_we_q;

        // writes are acknowledged with zero data
        rdata_sel = resp_we_q ? '0 : mem_rdata;
        p0_rvalid = resp_vld_q & ~resp_port_q;
        p1_rvalid = resp_vld_q & resp_port_q;
        p0_rdata  = p0_rvalid ? rdata_sel : '0;
        p1_rdata  = p1_rvalid ? rdata_sel : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q  <= 1'b1;
            resp_vld_q  <= 1'b0;
            resp_port_q <= 1'b0;
            resp_we_q   <= 1'b0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            resp_vld_q  <= resp_vld_d;
            resp_port_q <= resp_port_d;
            resp_we_q   <= resp_we_d;
        end
    end

    a_one_gnt: assert property (@(posedge clk) disable iff (!rst) !(p0_gnt && p1_gnt));
    a_gnt0_req: assert property (@(posedge clk) disable iff (!rst) p0_gnt |-> p0_req);
    a_gnt1_req: assert property (@(posedge clk) disable iff (!rst) p1_gnt |-> p1_req);
    a_rv0: assert property (@(posedge clk) disable iff (!rst) p0_rvalid |-> $past(p0_gnt));
    a_rv1: assert property (@(posedge clk) disable iff (!rst) p1_rvalid |-> $past(p1_gnt));

endmodule

// File: tb/tb_spram_arbiter.sv
// Randomized bench for spram_arbiter: round-robin instance with a RAM model and scoreboard,
// plus a fixed-priority instance sharing the same requests.
module tb_spram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic        b_p0_gnt, b_p0_rvalid, b_p1_gnt, b_p1_rvalid;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic        b_mem_re, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [31:0] b_mem_rdata = 32'hDEAD_BEEF;

    spram_arbiter #(.AddrBusWidth(32), .DataBusWidth(32), .RoundRobin(1'b1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    spram_arbiter #(.AddrBusWidth(32), .DataBusWidth(32), .RoundRobin(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    typedef struct {
        logic [31:0] cyc;
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        mit;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc_n = 0;
    logic [31:0] ram [0:255];
    logic [31:0] ref_mem [0:255];
    logic        rr_last;
    logic        ram_re, ram_we;
    logic [7:0]  ram_a;
    logic [31:0] ram_d;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Read-first single-port RAM with one cycle of read latency
    always begin
        @(posedge clk);
        ram_re = mem_re;
        ram_we = mem_we;
        ram_a  = mem_addr[7:0];
        ram_d  = mem_wdata;
        #1;
        if (ram_re) mem_rdata = ram[ram_a];
        if (ram_we) ram[ram_a] = ram_d;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        output logic g0, output logic g1);
        logic        e0, e1, f0, f1, ew;
        logic [31:0] ea, ed;
        exp_t        it;
        @(posedge clk);
        #1;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
        it.cyc = cyc_n;
        // On contention, round-robin serves whichever port did not win last time
        if (r0 && r1) begin
            e0 = rr_last;
            e1 = !rr_last;
        end else begin
            e0 = r0;
            e1 = r1;
        end
        f0 = r0;
        f1 = r1 && !r0;
        chk("gnt_rr", {p0_gnt, p1_gnt}, {e0, e1});
        chk("gnt_fixed", {b_p0_gnt, b_p1_gnt}, {f0, f1});
        ew = e0 ? w0 : w1;
        ea = e0 ? a0 : a1;
        ed = e0 ? d0 : d1;
        if (e0 || e1) begin
            chk("mem_bus", {mem_re, mem_we, mem_addr, mem_wdata}, {!ew, ew, ea, ed});
            it.port = e1;
            it.data = ew ? 32'h0 : ref_mem[ea[7:0]];
            if (ew) ref_mem[ea[7:0]] = ed;
            qa.push_back(it);
            rr_last = e1;
        end else begin
            chk("mem_bus_idle", {mem_re, mem_we, mem_addr, mem_wdata}, 128'h0);
        end
        if (f0 || f1) begin
            it.port = f1;
            it.data = (f0 ? w0 : w1) ? 32'h0 : 32'hDEAD_BEEF;
            qb.push_back(it);
        end
        g0 = e0;
        g1 = e1;
    endtask

    // Response monitor: pops the scoreboard whenever a response appears or is overdue
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_quiet", {p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, b_p0_rvalid, b_p1_rvalid}, 128'h0);
        end else begin
            if (p0_rvalid || p1_rvalid) begin
                if (qa.size() == 0) begin
                    chk("resp_unexpected", {p0_rvalid, p1_rvalid}, 2'b00);
                end else begin
                    mit = qa.pop_front();
                    chk("resp_port", {p0_rvalid, p1_rvalid}, mit.port ? 2'b01 : 2'b10);
                    chk("resp_data", mit.port ? p1_rdata : p0_rdata, mit.data);
                end
            end else if (qa.size() > 0 && qa[0].cyc < cyc_n) begin
                mit = qa.pop_front();
                chk("resp_missing", {p0_rvalid, p1_rvalid}, mit.port ? 2'b01 : 2'b10);
            end
            if (!p0_rvalid) chk("p0_rdata_idle", p0_rdata, 0);
            if (!p1_rvalid) chk("p1_rdata_idle", p1_rdata, 0);

            if (b_p0_rvalid || b_p1_rvalid) begin
                if (qb.size() == 0) begin
                    chk("fixed_resp_unexpected", {b_p0_rvalid, b_p1_rvalid}, 2'b00);
                end else begin
                    mit = qb.pop_front();
                    chk("fixed_resp_port", {b_p0_rvalid, b_p1_rvalid}, mit.port ? 2'b01 : 2'b10);
                    chk("fixed_resp_data", mit.port ? b_p1_rdata : b_p0_rdata, mit.data);
                end
            end else if (qb.size() > 0 && qb[0].cyc < cyc_n) begin
                mit = qb.pop_front();
                chk("fixed_resp_missing", {b_p0_rvalid, b_p1_rvalid}, mit.port ? 2'b01 : 2'b10);
            end
        end
    end

    logic        g0, g1;
    logic        pr0 = 0, pw0 = 0, pr1 = 0, pw1 = 0;
    logic [31:0] pa0 = 0, pd0 = 0, pa1 = 0, pd1 = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h1000_0000 + i * 32'h0101;
            ref_mem[i] = ram[i];
        end
        ram[16]     = 32'hAABB_CCDD;
        ref_mem[16] = 32'hAABB_CCDD;
        rr_last     = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // single read on port 0, then an idle cycle
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // continuous contention
        repeat (8) step(1, 0, 32'h4, 0, 1, 0, 32'h8, 0, g0, g1);

        // write on port 1 followed by a read of the same word on port 0
        step(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678, g0, g1);
        step(1, 0, 32'h20, 0, 0, 0, 0, 0, g0, g1);

        // port 1 loses a contention and then withdraws
        step(0, 0, 0, 0, 1, 0, 32'h3, 0, g0, g1);
        step(1, 0, 32'h5, 0, 1, 0, 32'h6, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // reset lands between a grant and its response
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, g0, g1);
        #1;
        rst = 1'b0;
        p0_req = 0; p1_req = 0;
        qa.delete();
        qb.delete();
        rr_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step(1, 0, 32'h1, 0, 1, 0, 32'h2, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        for (int n = 0; n < 400; n++) begin
            if (!pr0) begin
                if ($urandom_range(0, 9) < 7) begin
                    pr0 = 1; pw0 = ($urandom_range(0, 2) == 0);
                    pa0 = $urandom_range(0, 15); pd0 = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                pr0 = 0;
            end
            if (!pr1) begin
                if ($urandom_range(0, 9) < 7) begin
                    pr1 = 1; pw1 = ($urandom_range(0, 2) == 0);
                    pa1 = $urandom_range(0, 15); pd1 = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                pr1 = 0;
            end
            step(pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1, g0, g1);
            if (g0) pr0 = 0;
            if (g1) pr1 = 0;
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        chk("drain", qa.size() + qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
